// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage, directly downstream of EX.
//
// Purpose:
//   - Resolves PC-relative branches (beq/bne on the zero flag, jt/jf on the
//     flag picked by in_jf_cond) and drives the flush request upstream.
//   - Runs a req/ready handshake to the data memory and stalls IF/ID/EX and
//     the EX/MEM register while an access is outstanding.
//   - Registers the MEM/WB fields for the writeback stage.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_*                EX/MEM register fields
//   branch_taken/target flush request and redirect PC
//   stall               hold upstream stages and the EX/MEM register
//   dmem_*              data memory request/response
//   out_*               MEM/WB register fields
//   mem_err             sticky access timeout flag
//
// Build option:
//   MEM_TIMEOUT_EN      when defined, an access that waits 255 cycles without
//                       dmem_ready is abandoned, a bubble is written and
//                       mem_err is set until reset. Otherwise ACCESS waits
//                       indefinitely and mem_err is tied low.
module mem_stage #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int REG_AW   = 4,
    parameter int ZERO_BIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_mem_write_enable,
    input  logic              in_mem_read,
    input  logic              in_sel_beq_bne,
    input  logic              in_sel_jt_jf,
    input  logic              in_is_branch,
    input  logic              in_sel_jflag_branch,
    input  logic [2:0]        in_jf_cond,
    input  logic [1:0]        in_wb_res_mux,
    input  logic              in_reg_write_enable,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [PC_W-1:0]   in_next_pc,
    input  logic [PC_W-1:0]   in_branch_addr,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_addr,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [5:0]        in_flags,
    input  logic [REG_AW-1:0] in_reg_dest,
    output logic              branch_taken,
    output logic [PC_W-1:0]   branch_target,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [1:0]        out_wb_res_mux,
    output logic              out_reg_write_enable,
    output logic [REG_AW-1:0] out_reg_dest,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_mem_rdata,
    output logic [DATA_W-1:0] out_imm,
    output logic [PC_W-1:0]   out_next_pc,
    output logic              mem_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                we_r;

    logic                mem_op_s;
    logic                stall_s;
    logic                capture_s;
    logic                pass_s;
    logic                bubble_s;
    logic                rdata_upd_s;
    logic                timeout_s;
    logic                flag_s;
    logic                flag_ok_s;
    logic                cond_s;

    // A simultaneous read+write is treated as a write: we follows in_mem_write_enable.
    assign mem_op_s = in_mem_read | in_mem_write_enable;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_r;
    logic       mem_err_r;

    assign timeout_s = (state_r == ACCESS) && !dmem_ready && (wait_cnt_r == 8'd255);
    assign mem_err   = mem_err_r;

    // Wait counter: cleared on entry to ACCESS, counts unanswered ACCESS cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 8'd0;
        end else if (capture_s) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r == ACCESS) && !dmem_ready) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err_r <= 1'b0;
        end else if (timeout_s) begin
            mem_err_r <= 1'b1;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Flag select for jt/jf; indices 6 and 7 are not real flags and never branch.
    always_comb begin
        flag_s    = 1'b0;
        flag_ok_s = 1'b0;
        case (in_jf_cond)
            3'd0:    begin flag_s = in_flags[0]; flag_ok_s = 1'b1; end
            3'd1:    begin flag_s = in_flags[1]; flag_ok_s = 1'b1; end
            3'd2:    begin flag_s = in_flags[2]; flag_ok_s = 1'b1; end
            3'd3:    begin flag_s = in_flags[3]; flag_ok_s = 1'b1; end
            3'd4:    begin flag_s = in_flags[4]; flag_ok_s = 1'b1; end
            3'd5:    begin flag_s = in_flags[5]; flag_ok_s = 1'b1; end
            default: begin flag_s = 1'b0;        flag_ok_s = 1'b0; end
        endcase
    end

    // Branch condition: flag branch or zero-flag branch, polarity from the selects.
    always_comb begin
        cond_s = 1'b0;
        if (in_sel_jflag_branch) begin
            cond_s = flag_ok_s & (flag_s ^ in_sel_jt_jf);
        end else begin
            cond_s = in_flags[ZERO_BIT] ^ in_sel_beq_bne;
        end
    end

    assign branch_taken  = in_is_branch & cond_s & ~stall_s;
    assign branch_target = in_branch_addr;
    assign stall         = stall_s;

    // Requests come straight off the state and capture registers so they stay
    // stable for the whole access and vanish the instant reset is asserted.
    assign dmem_req   = (state_r == ACCESS);
    assign dmem_we    = (state_r == ACCESS) & we_r;
    assign dmem_addr  = addr_r;
    assign dmem_wdata = wdata_r;

    // Next-state and per-cycle MEM/WB load decisions.
    always_comb begin
        state_s     = state_r;
        stall_s     = 1'b0;
        capture_s   = 1'b0;
        pass_s      = 1'b0;
        bubble_s    = 1'b0;
        rdata_upd_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    stall_s   = 1'b1;
                    capture_s = 1'b1;
                    bubble_s  = 1'b1;
                    state_s   = ACCESS;
                end else begin
                    pass_s = 1'b1;
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    pass_s      = 1'b1;
                    rdata_upd_s = ~we_r;
                    state_s     = IDLE;
                end else if (timeout_s) begin
                    bubble_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                end
            end
            default: begin
                bubble_s = 1'b1;
                state_s  = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture the access parameters so the bus stays stable while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= '0;
            wdata_r <= '0;
            we_r    <= 1'b0;
        end else if (capture_s) begin
            addr_r  <= in_mem_addr;
            wdata_r <= in_mem_data;
            we_r    <= in_mem_write_enable;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            we_r    <= we_r;
        end
    end

    // MEM/WB register: pass-through on completion, bubble (write disabled) while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wb_res_mux       <= 2'd0;
            out_reg_write_enable <= 1'b0;
            out_reg_dest         <= '0;
            out_alu_res          <= '0;
            out_imm              <= '0;
            out_next_pc          <= '0;
        end else if (pass_s) begin
            out_wb_res_mux       <= in_wb_res_mux;
            out_reg_write_enable <= in_reg_write_enable;
            out_reg_dest         <= in_reg_dest;
            out_alu_res          <= in_alu_res;
            out_imm              <= in_imm;
            out_next_pc          <= in_next_pc;
        end else if (bubble_s) begin
            out_reg_write_enable <= 1'b0;
        end else begin
            out_reg_write_enable <= out_reg_write_enable;
        end
    end

    // Load data field: updated only when a load completes, otherwise held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_mem_rdata <= '0;
        end else if (rdata_upd_s) begin
            out_mem_rdata <= dmem_rdata;
        end else begin
            out_mem_rdata <= out_mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Each instruction pushes
// its expected MEM/WB contents to a scoreboard queue when driven; the entry
// is popped and compared on the edge where the stage releases the stall.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_mem_write_enable, in_mem_read, in_sel_beq_bne, in_sel_jt_jf;
    logic        in_is_branch, in_sel_jflag_branch, in_reg_write_enable;
    logic [2:0]  in_jf_cond;
    logic [1:0]  in_wb_res_mux;
    logic [31:0] in_imm, in_next_pc, in_branch_addr, in_alu_res, in_mem_addr, in_mem_data;
    logic [5:0]  in_flags;
    logic [3:0]  in_reg_dest;
    logic        branch_taken, stall, dmem_req, dmem_we, dmem_ready, mem_err;
    logic [31:0] branch_target, dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  out_wb_res_mux;
    logic        out_reg_write_enable;
    logic [3:0]  out_reg_dest;
    logic [31:0] out_alu_res, out_mem_rdata, out_imm, out_next_pc;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .in_mem_write_enable(in_mem_write_enable), .in_mem_read(in_mem_read),
        .in_sel_beq_bne(in_sel_beq_bne), .in_sel_jt_jf(in_sel_jt_jf),
        .in_is_branch(in_is_branch), .in_sel_jflag_branch(in_sel_jflag_branch),
        .in_jf_cond(in_jf_cond), .in_wb_res_mux(in_wb_res_mux),
        .in_reg_write_enable(in_reg_write_enable), .in_imm(in_imm),
        .in_next_pc(in_next_pc), .in_branch_addr(in_branch_addr),
        .in_alu_res(in_alu_res), .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data),
        .in_flags(in_flags), .in_reg_dest(in_reg_dest),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .out_wb_res_mux(out_wb_res_mux), .out_reg_write_enable(out_reg_write_enable),
        .out_reg_dest(out_reg_dest), .out_alu_res(out_alu_res),
        .out_mem_rdata(out_mem_rdata), .out_imm(out_imm), .out_next_pc(out_next_pc),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, data;
        logic [1:0]  wbm;
        logic        rwe;
        logic [3:0]  rdst;
        logic [31:0] alu, imm, npc;
        int          waits;
        logic [31:0] rdat;
        logic        br, selj, selbne, seljf;
        logic [2:0]  jc;
        logic [5:0]  fl;
        logic [31:0] btgt;
        logic        taken;
    } op_t;

    typedef struct {
        logic [1:0]  wbm;
        logic        rwe;
        logic [3:0]  rdst;
        logic [31:0] alu, rdata, imm, npc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata = 32'h0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic op_t new_op();
        op_t o;
        o = '{default: '0};
        return o;
    endfunction

    task automatic drive_idle();
        in_mem_write_enable = 1'b0; in_mem_read = 1'b0; in_sel_beq_bne = 1'b0;
        in_sel_jt_jf = 1'b0; in_is_branch = 1'b0; in_sel_jflag_branch = 1'b0;
        in_jf_cond = 3'd0; in_wb_res_mux = 2'd0; in_reg_write_enable = 1'b0;
        in_imm = 32'h0; in_next_pc = 32'h0; in_branch_addr = 32'h0; in_alu_res = 32'h0;
        in_mem_addr = 32'h0; in_mem_data = 32'h0; in_flags = 6'h0; in_reg_dest = 4'h0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
    endtask

    // Drive one instruction (called just after a rising edge), act as the
    // memory, and compare the MEM/WB register once the stage completes it.
    task automatic do_op(input string name, input op_t o);
        exp_t e;
        logic mem;
        int   cyc, stalls, we_cycles;
        logic bus_ok, done;
        mem = o.rd | o.wr;
        in_mem_read = o.rd; in_mem_write_enable = o.wr;
        in_mem_addr = o.addr; in_mem_data = o.data;
        in_wb_res_mux = o.wbm; in_reg_write_enable = o.rwe; in_reg_dest = o.rdst;
        in_alu_res = o.alu; in_imm = o.imm; in_next_pc = o.npc;
        in_is_branch = o.br; in_sel_jflag_branch = o.selj; in_sel_beq_bne = o.selbne;
        in_sel_jt_jf = o.seljf; in_jf_cond = o.jc; in_flags = o.fl;
        in_branch_addr = o.btgt; dmem_rdata = o.rdat;
        if (o.rd && !o.wr) model_rdata = o.rdat;
        e.wbm = o.wbm; e.rwe = o.rwe; e.rdst = o.rdst; e.alu = o.alu;
        e.rdata = model_rdata; e.imm = o.imm; e.npc = o.npc;
        sb.push_back(e);
        cyc = 0; stalls = 0; we_cycles = 0; bus_ok = 1'b1; done = 1'b0;
        while (!done && cyc < 300) begin
            dmem_ready = mem && (cyc > o.waits);
            #3;
            if (cyc == 0) begin
                check({name, ".req_idle"}, 32'(dmem_req), 32'h0);
                if (o.br) begin
                    check({name, ".taken"}, 32'(branch_taken), 32'(o.taken));
                    check({name, ".target"}, branch_target, o.btgt);
                end
            end
            if (dmem_req) begin
                if (dmem_addr !== o.addr || dmem_wdata !== o.data) bus_ok = 1'b0;
                if (dmem_we) we_cycles++;
            end
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, ".completed"}, 32'(done), 32'h1);
        drive_idle();
        check({name, ".stall_cycles"}, 32'(stalls), mem ? 32'(o.waits + 1) : 32'h0);
        if (mem) begin
            check({name, ".bus_stable"}, 32'(bus_ok), 32'h1);
            check({name, ".we_cycles"}, 32'(we_cycles), o.wr ? 32'h1 : 32'h0);
        end
        e = sb.pop_front();
        check({name, ".wbm"}, 32'(out_wb_res_mux), 32'(e.wbm));
        check({name, ".rwe"}, 32'(out_reg_write_enable), 32'(e.rwe));
        check({name, ".rdst"}, 32'(out_reg_dest), 32'(e.rdst));
        check({name, ".alu"}, out_alu_res, e.alu);
        check({name, ".rdata"}, out_mem_rdata, e.rdata);
        check({name, ".imm"}, out_imm, e.imm);
        check({name, ".npc"}, out_next_pc, e.npc);
    endtask

    initial begin
        op_t o;
        drive_idle();
        #1;
        check("rst.req", 32'(dmem_req), 32'h0);
        check("rst.we", 32'(dmem_we), 32'h0);
        check("rst.stall", 32'(stall), 32'h0);
        check("rst.taken", 32'(branch_taken), 32'h0);
        check("rst.rwe", 32'(out_reg_write_enable), 32'h0);
        check("rst.alu", out_alu_res, 32'h0);
        check("rst.mem_err", 32'(mem_err), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        o = new_op(); o.alu = 32'h1234; o.rdst = 4'd3; o.rwe = 1'b1; o.wbm = 2'd2;
        o.imm = 32'h7; o.npc = 32'h101;
        do_op("alu", o);

        o = new_op(); o.rd = 1'b1; o.addr = 32'h40; o.waits = 2; o.rdat = 32'hDEADBEEF;
        o.rwe = 1'b1; o.rdst = 4'd5; o.wbm = 2'd1; o.alu = 32'h40; o.npc = 32'h102;
        do_op("load_w2", o);

        o = new_op(); o.wr = 1'b1; o.addr = 32'h10; o.data = 32'h55; o.waits = 0;
        o.rdat = 32'hBAD0BAD0; o.npc = 32'h103; o.alu = 32'h10;
        do_op("store", o);

        o = new_op(); o.rd = 1'b1; o.addr = 32'h44; o.waits = 0; o.rdat = 32'hCAFE0001;
        o.rwe = 1'b1; o.rdst = 4'd6; o.wbm = 2'd1; o.npc = 32'h104;
        do_op("load_w0", o);

        o = new_op(); o.rd = 1'b1; o.addr = 32'h48; o.waits = 1; o.rdat = 32'h0BADF00D;
        o.rwe = 1'b1; o.rdst = 4'd7; o.wbm = 2'd1; o.npc = 32'h105;
        do_op("load_b2b", o);

        o = new_op(); o.br = 1'b1; o.fl = 6'b000001; o.btgt = 32'h200; o.taken = 1'b1;
        o.npc = 32'h106;
        do_op("beq", o);

        o = new_op(); o.br = 1'b1; o.selbne = 1'b1; o.fl = 6'b000001; o.btgt = 32'h204;
        o.taken = 1'b0; o.npc = 32'h107;
        do_op("bne", o);

        o = new_op(); o.br = 1'b1; o.selj = 1'b1; o.seljf = 1'b1; o.jc = 3'd3;
        o.fl = 6'b110111; o.btgt = 32'h300; o.taken = 1'b1; o.npc = 32'h108;
        do_op("jf3", o);

        o = new_op(); o.br = 1'b1; o.selj = 1'b1; o.jc = 3'd5; o.fl = 6'b100000;
        o.btgt = 32'h304; o.taken = 1'b1; o.npc = 32'h109;
        do_op("jt5", o);

        o = new_op(); o.br = 1'b1; o.selj = 1'b1; o.seljf = 1'b1; o.jc = 3'd6;
        o.fl = 6'b000000; o.btgt = 32'h308; o.taken = 1'b0; o.npc = 32'h10A;
        do_op("jf6", o);

        // Reset in the middle of a pending load.
        in_mem_read = 1'b1; in_mem_addr = 32'h80; in_reg_write_enable = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("mid.req_before", 32'(dmem_req), 32'h1);
        drive_idle();
        rst = 1'b0;
        #1;
        check("mid.req", 32'(dmem_req), 32'h0);
        check("mid.stall", 32'(stall), 32'h0);
        check("mid.rwe", 32'(out_reg_write_enable), 32'h0);
        check("mid.alu", out_alu_res, 32'h0);
        check("mid.rdata", out_mem_rdata, 32'h0);
        check("mid.npc", out_next_pc, 32'h0);
        model_rdata = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        o = new_op(); o.alu = 32'h5A5A; o.rdst = 4'd9; o.rwe = 1'b1; o.npc = 32'h200;
        do_op("alu_post_rst", o);

`ifdef MEM_TIMEOUT_EN
        begin
            int stalls;
            in_mem_read = 1'b1; in_mem_addr = 32'h90; in_reg_write_enable = 1'b1;
            stalls = 0;
            for (int i = 0; i < 400 && (i == 0 || stall); i++) begin
                #3;
                if (stall) stalls++;
                @(posedge clk);
                #1;
            end
            drive_idle();
            check("tmo.stall_cycles", 32'(stalls), 32'd256);
            check("tmo.mem_err", 32'(mem_err), 32'h1);
            check("tmo.rwe", 32'(out_reg_write_enable), 32'h0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
